// File: rtl/toy_bus_arb_node_rr_ack_if.sv
// toy_bus_arb_node_rr_ack_if: ToyBusAck merge bundle (NUM_IN requesters in, one registered stream out)
interface toy_bus_arb_node_rr_ack_if #(
    parameter int NUM_IN = 2,
    parameter int DATA_W = 256,
    parameter int SB_W   = 32,
    parameter int ID_W   = 4
);
    localparam int IDX_W = $clog2(NUM_IN);
    logic [NUM_IN-1:0]        in_vld;
    logic [NUM_IN-1:0]        in_rdy;
    logic [NUM_IN-1:0]        in_opcode;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN*SB_W-1:0]   in_sideband;
    logic [NUM_IN*ID_W-1:0]   in_src_id;
    logic [NUM_IN*ID_W-1:0]   in_tgt_id;
    logic                     out_vld;
    logic                     out_rdy;
    logic                     out_opcode;
    logic [DATA_W-1:0]        out_data;
    logic [SB_W-1:0]          out_sideband;
    logic [ID_W-1:0]          out_src_id;
    logic [ID_W-1:0]          out_tgt_id;
    logic [IDX_W-1:0]         grant_idx;
    modport master (
        output in_vld, in_opcode, in_data, in_sideband, in_src_id, in_tgt_id, out_rdy,
        input  in_rdy, out_vld, out_opcode, out_data, out_sideband, out_src_id, out_tgt_id, grant_idx
    );
    modport slave (
        input  in_vld, in_opcode, in_data, in_sideband, in_src_id, in_tgt_id, out_rdy,
        output in_rdy, out_vld, out_opcode, out_data, out_sideband, out_src_id, out_tgt_id, grant_idx
    );
endinterface

// File: rtl/toy_bus_arb_node_rr_ack.sv
// toy_bus_arb_node_rr_ack: round-robin merge of NUM_IN ack streams into one registered output stage
module toy_bus_arb_node_rr_ack #(
    parameter int NUM_IN = 2,
    parameter int DATA_W = 256,
    parameter int SB_W   = 32,
    parameter int ID_W   = 4
) (
    input  logic clk,
    input  logic rst,
    toy_bus_arb_node_rr_ack_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_IN);
    logic [NUM_IN-1:0] gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  rr_ptr;
    logic              load_en;
    logic              xfer;
    logic              found;
    logic              sel_opcode;
    logic [DATA_W-1:0] sel_data;
    logic [SB_W-1:0]   sel_sideband;
    logic [ID_W-1:0]   sel_src_id;
    logic [ID_W-1:0]   sel_tgt_id;
    assign load_en = !bus.out_vld || bus.out_rdy;
    assign bus.in_rdy = rst ? '0 : gnt & {NUM_IN{load_en}};
    assign xfer = |bus.in_rdy;
    // first valid input at or after rr_ptr, wrapping
    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            int j;
            j = (int'(rr_ptr) + k) % NUM_IN;
            if (!found && bus.in_vld[IDX_W'(j)]) begin
                found = 1'b1;
                gnt[IDX_W'(j)] = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
    end
    always_comb begin
        sel_opcode = 1'b0;
        sel_data = '0;
        sel_sideband = '0;
        sel_src_id = '0;
        sel_tgt_id = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt[i]) begin
                sel_opcode = bus.in_opcode[i];
                sel_data = bus.in_data[i*DATA_W +: DATA_W];
                sel_sideband = bus.in_sideband[i*SB_W +: SB_W];
                sel_src_id = bus.in_src_id[i*ID_W +: ID_W];
                sel_tgt_id = bus.in_tgt_id[i*ID_W +: ID_W];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_vld <= 1'b0;
            bus.out_opcode <= 1'b0;
            bus.out_data <= '0;
            bus.out_sideband <= '0;
            bus.out_src_id <= '0;
            bus.out_tgt_id <= '0;
            bus.grant_idx <= '0;
            rr_ptr <= '0;
        end else if (xfer) begin
            bus.out_vld <= 1'b1;
            bus.out_opcode <= sel_opcode;
            bus.out_data <= sel_data;
            bus.out_sideband <= sel_sideband;
            bus.out_src_id <= sel_src_id;
            bus.out_tgt_id <= sel_tgt_id;
            bus.grant_idx <= gnt_idx;
            rr_ptr <= (gnt_idx == IDX_W'(NUM_IN-1)) ? '0 : gnt_idx + 1'b1;
        end else if (bus.out_rdy) begin
            bus.out_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_toy_bus_arb_node_rr_ack.sv
// tb_toy_bus_arb_node_rr_ack: scenario tasks plus random traffic against a transaction-level model
module tb_toy_bus_arb_node_rr_ack;
    localparam int N = 2;
    localparam int DW = 256;
    localparam int SW = 32;
    localparam int IW = 4;
    localparam int XW = $clog2(N);
    localparam int OW = XW + 1 + DW + SW + 2*IW;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int passes = 0;
    logic          m_vld;
    logic [OW-1:0] m_out;
    int            m_ptr;
    logic [OW-1:0] dut_out;
    toy_bus_arb_node_rr_ack_if #(.NUM_IN(N), .DATA_W(DW), .SB_W(SW), .ID_W(IW)) bus ();
    toy_bus_arb_node_rr_ack #(.NUM_IN(N), .DATA_W(DW), .SB_W(SW), .ID_W(IW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    assign dut_out = {bus.grant_idx, bus.out_opcode, bus.out_data, bus.out_sideband, bus.out_src_id, bus.out_tgt_id};

    function automatic int winner();
        for (int k = 0; k < N; k++)
            if (bus.in_vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_rdy();
        logic [N-1:0] r;
        int w;
        r = '0;
        w = winner();
        if (!rst && (!m_vld || bus.out_rdy) && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic drive(input logic [N-1:0] vld, input logic ordy);
        bus.in_vld = vld;
        bus.out_rdy = ordy;
        for (int i = 0; i < N; i++) begin
            bus.in_opcode[i] = 1'($urandom);
            bus.in_data[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            bus.in_sideband[i*SW +: SW] = $urandom;
            bus.in_src_id[i*IW +: IW] = IW'($urandom);
            bus.in_tgt_id[i*IW +: IW] = IW'($urandom);
        end
    endtask

    // model advances on the edge using the inputs the DUT sees, then moves to the next negedge
    task automatic tick();
        int w;
        w = winner();
        if (rst) begin
            m_vld = 1'b0;
            m_out = '0;
            m_ptr = 0;
        end else if ((!m_vld || bus.out_rdy) && w >= 0) begin
            m_vld = 1'b1;
            m_out = {XW'(w), bus.in_opcode[w], bus.in_data[w*DW +: DW], bus.in_sideband[w*SW +: SW],
                     bus.in_src_id[w*IW +: IW], bus.in_tgt_id[w*IW +: IW]};
            m_ptr = (w + 1) % N;
        end else if (bus.out_rdy) begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            rst = 1'b1;
            drive(2'b11, 1'b1);
            #1;
            checks++;
            if (bus.in_rdy !== 2'b00 || bus.out_vld !== 1'b0 || bus.out_data !== '0)
                $display("FAIL reset: in_rdy=%b out_vld=%b out_data=%h, want 00/0/0", bus.in_rdy, bus.out_vld, bus.out_data);
            else passes++;
            tick();
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_rdy !== 2'b01) $display("FAIL reset_first_grant: in_rdy=%b want 01", bus.in_rdy);
        else passes++;
    endtask

    task automatic test_alternate();
        for (int c = 0; c < 8; c++) begin
            drive(2'b11, 1'b1);
            bus.in_data = {{64{4'hB}}, {64{4'hA}}};
            #1;
            checks++;
            if (bus.in_rdy !== exp_rdy() || bus.out_vld !== m_vld || (m_vld && dut_out !== m_out))
                $display("FAIL alternate: rdy=%b/%b vld=%b/%b out=%h/%h", bus.in_rdy, exp_rdy(), bus.out_vld, m_vld, dut_out, m_out);
            else passes++;
            tick();
            checks++;
            if (bus.out_data[3:0] !== ((c % 2 == 0) ? 4'hA : 4'hB) || bus.grant_idx !== XW'(c % 2))
                $display("FAIL alternate_seq: data=%h idx=%0d, want %h/%0d", bus.out_data[3:0], bus.grant_idx, (c % 2 == 0) ? 4'hA : 4'hB, c % 2);
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        drive(2'b01, 1'b1);
        bus.in_src_id[IW-1:0] = 4'd3;
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 1'b0);
            #1;
            checks++;
            if (bus.in_rdy !== 2'b00 || bus.out_vld !== 1'b1 || bus.out_src_id !== 4'd3 || dut_out !== m_out)
                $display("FAIL backpressure: rdy=%b vld=%b src=%0d out=%h/%h", bus.in_rdy, bus.out_vld, bus.out_src_id, dut_out, m_out);
            else passes++;
            tick();
        end
        drive(2'b11, 1'b1);
        #1;
        checks++;
        if (bus.in_rdy !== 2'b10) $display("FAIL release_no_bubble: in_rdy=%b want 10", bus.in_rdy);
        else passes++;
        tick();
        checks++;
        if (bus.out_vld !== 1'b1 || bus.grant_idx !== 1'b1 || dut_out !== m_out)
            $display("FAIL release_load: vld=%b idx=%0d out=%h/%h", bus.out_vld, bus.grant_idx, dut_out, m_out);
        else passes++;
    endtask

    task automatic test_single();
        for (int c = 0; c < 5; c++) begin
            drive(2'b10, 1'b1);
            bus.in_tgt_id[IW +: IW] = 4'd1;
            tick();
            checks++;
            if (bus.out_vld !== 1'b1 || bus.grant_idx !== 1'b1 || bus.out_tgt_id !== 4'd1 || dut_out !== m_out)
                $display("FAIL single: vld=%b idx=%0d tgt=%0d out=%h/%h", bus.out_vld, bus.grant_idx, bus.out_tgt_id, dut_out, m_out);
            else passes++;
        end
        drive(2'b11, 1'b1);
        #1;
        checks++;
        if (bus.in_rdy !== 2'b01) $display("FAIL single_wrap: in_rdy=%b want 01", bus.in_rdy);
        else passes++;
        tick();
    endtask

    task automatic test_idle();
        drive(2'b01, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(2'b00, 1'b1);
            tick();
        end
        checks++;
        if (bus.out_vld !== 1'b0) $display("FAIL idle_drain: out_vld=%b want 0", bus.out_vld);
        else passes++;
        drive(2'b11, 1'b1);
        #1;
        checks++;
        if (bus.in_rdy !== 2'b10) $display("FAIL idle_ptr: in_rdy=%b want 10", bus.in_rdy);
        else passes++;
        tick();
    endtask

    task automatic test_reset_mid();
        drive(2'b01, 1'b1);
        tick();
        drive(2'b11, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_rdy !== 2'b00 || bus.out_vld !== 1'b1) $display("FAIL reset_mid_hold: rdy=%b vld=%b want 00/1", bus.in_rdy, bus.out_vld);
        else passes++;
        tick();
        rst = 1'b0;
        drive(2'b11, 1'b1);
        #1;
        checks++;
        if (bus.out_vld !== 1'b0 || bus.in_rdy !== 2'b01) $display("FAIL reset_mid: vld=%b rdy=%b want 0/01", bus.out_vld, bus.in_rdy);
        else passes++;
        tick();
        checks++;
        if (bus.out_vld !== 1'b1 || bus.grant_idx !== 1'b0 || dut_out !== m_out)
            $display("FAIL reset_mid_regrant: vld=%b idx=%0d out=%h/%h", bus.out_vld, bus.grant_idx, dut_out, m_out);
        else passes++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(N'($urandom), ($urandom_range(0, 9) < 7));
            rst = ($urandom_range(0, 99) == 0);
            #1;
            checks++;
            if (bus.in_rdy !== exp_rdy() || bus.out_vld !== m_vld || (m_vld && dut_out !== m_out))
                $display("FAIL random[%0d]: rdy=%b/%b vld=%b/%b out=%h/%h", c, bus.in_rdy, exp_rdy(), bus.out_vld, m_vld, dut_out, m_out);
            else passes++;
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        m_vld = 1'b0;
        m_out = '0;
        m_ptr = 0;
        drive(2'b00, 1'b0);
        @(negedge clk);
        test_reset();
        test_alternate();
        test_backpressure();
        test_single();
        test_idle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
